clk_pll_sequencer: RTL and testbench

CLK_PLL_SEQUENCER -- requirements
Module: clk_pll_sequencer

---
 rtl/clk_pll_sequencer.sv | 141 ++++++++++++++
 tb/tb_clk_pll_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_pll_sequencer.sv
// Sequences divider reprogramming of one of NumPlls PLLs: gate its clock, program, wait for a
// stable lock, then ungate. Bad indices and lock timeouts raise a sticky error flag.
module clk_pll_sequencer #(
   parameter int unsigned NumPlls       = 3,
   parameter int unsigned DivWidth      = 8,
   parameter int unsigned GateCycles    = 4,
   parameter int unsigned LockCycles    = 16,
   parameter int unsigned TimeoutCycles = 1024,
   localparam int unsigned IdxW         = (NumPlls > 1) ? $clog2(NumPlls) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [IdxW-1:0]     cfg_idx_i,
   input  logic [DivWidth-1:0] cfg_div_i,
   input  logic                cfg_en_i,
   output logic                pll_cfg_valid_o,
   input  logic                pll_cfg_ready_i,
   output logic [IdxW-1:0]     pll_cfg_idx_o,
   output logic [DivWidth-1:0] pll_cfg_div_o,
   input  logic [NumPlls-1:0]  pll_lock_i,
   output logic [NumPlls-1:0]  clk_en_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned MaxGl  = (GateCycles > LockCycles) ? GateCycles : LockCycles;
   localparam int unsigned MaxCnt = (MaxGl > TimeoutCycles) ? MaxGl : TimeoutCycles;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] GateLast = CntW'(GateCycles - 1);
   localparam logic [CntW-1:0] LockLast = CntW'(LockCycles - 1);
   localparam logic [CntW-1:0] ToutLast = CntW'(TimeoutCycles - 1);

   typedef enum logic [2:0] {StIdle, StGate, StProg, StLock, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;    // gate length, then consecutive-lock run
   logic [CntW-1:0]     tout_q, tout_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [DivWidth-1:0] div_q, div_d;
   logic                en_q, en_d;
   logic                err_q, err_d;
   logic [NumPlls-1:0]  clk_en_q, clk_en_d;
   logic                lock_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         tout_q   <= '0;
         idx_q    <= '0;
         div_q    <= '0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
         clk_en_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
         idx_q    <= idx_d;
         div_q    <= div_d;
         en_q     <= en_d;
         err_q    <= err_d;
         clk_en_q <= clk_en_d;
      end
   end

   assign lock_done = pll_lock_i[idx_q] && (cnt_q == LockLast);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tout_d   = tout_q;
      idx_d    = idx_q;
      div_d    = div_q;
      en_d     = en_q;
      err_d    = err_q;
      clk_en_d = clk_en_q;
      unique case (state_q)
         StIdle: begin
            if (cfg_valid_i) begin
               idx_d  = cfg_idx_i;
               div_d  = cfg_div_i;
               en_d   = cfg_en_i;
               cnt_d  = '0;
               tout_d = '0;
               if (32'(cfg_idx_i) >= NumPlls) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  err_d               = 1'b0;
                  clk_en_d[cfg_idx_i] = 1'b0;
                  state_d             = StGate;
               end
            end
         end
         StGate: begin
            if (cnt_q == GateLast) begin
               cnt_d   = '0;
               state_d = en_q ? StProg : StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StProg: begin
            if (pll_cfg_ready_i) begin
               cnt_d   = '0;
               tout_d  = '0;
               state_d = StLock;
            end
         end
         StLock: begin
            tout_d = tout_q + 1'b1;
            cnt_d  = pll_lock_i[idx_q] ? cnt_q + 1'b1 : '0;
            // Lock completion takes priority over a coincident timeout.
            if (lock_done) begin
               clk_en_d[idx_q] = 1'b1;
               state_d         = StDone;
            end else if (tout_q == ToutLast) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign cfg_ready_o     = (state_q == StIdle);
   assign pll_cfg_valid_o = (state_q == StProg);
   assign pll_cfg_idx_o   = idx_q;
   assign pll_cfg_div_o   = div_q;
   assign clk_en_o        = clk_en_q;
   assign busy_o          = (state_q != StIdle);
   assign done_o          = (state_q == StDone);
   assign err_o           = err_q;

endmodule

// File: tb/tb_clk_pll_sequencer.sv
// Directed bench for clk_pll_sequencer at default parameters; cycle 0 is the accept cycle.
module tb_clk_pll_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_valid, cfg_ready, cfg_en;
   logic [1:0] cfg_idx;
   logic [7:0] cfg_div;
   logic       pll_valid, pll_ready;
   logic [1:0] pll_idx;
   logic [7:0] pll_div;
   logic [2:0] pll_lock, clk_en;
   logic       busy, done, err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   clk_pll_sequencer dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .cfg_valid_i     (cfg_valid),
      .cfg_ready_o     (cfg_ready),
      .cfg_idx_i       (cfg_idx),
      .cfg_div_i       (cfg_div),
      .cfg_en_i        (cfg_en),
      .pll_cfg_valid_o (pll_valid),
      .pll_cfg_ready_i (pll_ready),
      .pll_cfg_idx_o   (pll_idx),
      .pll_cfg_div_o   (pll_div),
      .pll_lock_i      (pll_lock),
      .clk_en_o        (clk_en),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle; DUT must be idle.
   task automatic issue(input logic [1:0] idx, input logic [7:0] div, input logic en);
      cfg_idx   = idx;
      cfg_div   = div;
      cfg_en    = en;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_div = '0; cfg_en = 1'b0;
      pll_ready = 1'b1; pll_lock = '0;
      #12;
      n_cmp++; if (clk_en !== 3'b000) begin n_fail++; $display("FAIL reset_clk_en: got %b want 000", clk_en); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (pll_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pll_valid: got %b want 0", pll_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
      step();
   endtask

   task automatic test_happy();
      pll_ready = 1'b1; pll_lock = 3'b010;
      issue(2'd1, 8'h20, 1'b1);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         n_cmp++; if (clk_en[1] !== (c == 22)) begin n_fail++; $display("FAIL happy_clk_en c%0d: got %b want %b", c, clk_en[1], c == 22); end
         n_cmp++; if (done !== (c == 22)) begin n_fail++; $display("FAIL happy_done c%0d: got %b want %b", c, done, c == 22); end
         n_cmp++; if (pll_valid !== (c == 5)) begin n_fail++; $display("FAIL happy_pll_valid c%0d: got %b want %b", c, pll_valid, c == 5); end
         if (c == 5) begin
            n_cmp++; if (pll_div !== 8'h20) begin n_fail++; $display("FAIL happy_div: got %h want 20", pll_div); end
            n_cmp++; if (pll_idx !== 2'd1) begin n_fail++; $display("FAIL happy_idx: got %0d want 1", pll_idx); end
         end
         if (c < 22) step();
      end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL happy_err: got %b want 0", err); end
      n_cmp++; if (clk_en !== 3'b010) begin n_fail++; $display("FAIL happy_clk_en_all: got %b want 010", clk_en); end
      step();
   endtask

   task automatic test_glitch();
      pll_lock = 3'b010;
      issue(2'd0, 8'h11, 1'b1);
      for (int c = 1; c <= 33; c++) begin
         pll_lock[0] = ((c >= 6) && (c <= 15)) || (c >= 17);
         @(negedge clk);
         n_cmp++; if (done !== (c == 33)) begin n_fail++; $display("FAIL glitch_done c%0d: got %b want %b", c, done, c == 33); end
         n_cmp++; if (clk_en !== ((c == 33) ? 3'b011 : 3'b010)) begin n_fail++; $display("FAIL glitch_clk_en c%0d: got %b", c, clk_en); end
         if (c < 33) step();
      end
      step();
   endtask

   task automatic test_timeout();
      pll_lock = 3'b000;
      issue(2'd2, 8'h33, 1'b1);
      for (int c = 1; c <= 1030; c++) begin
         @(negedge clk);
         n_cmp++; if (done !== (c == 1030)) begin n_fail++; $display("FAIL timeout_done c%0d: got %b want %b", c, done, c == 1030); end
         if (c == 1029) begin
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_early: got %b want 0", err); end
         end
         if (c == 1030) begin
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
            n_cmp++; if (clk_en !== 3'b011) begin n_fail++; $display("FAIL timeout_clk_en: got %b want 011", clk_en); end
         end
         if (c < 1030) step();
      end
      step();
   endtask

   task automatic test_gate_only();
      issue(2'd0, 8'h44, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         n_cmp++; if (pll_valid !== 1'b0) begin n_fail++; $display("FAIL gate_pll_valid c%0d: got %b want 0", c, pll_valid); end
         n_cmp++; if (done !== (c == 5)) begin n_fail++; $display("FAIL gate_done c%0d: got %b want %b", c, done, c == 5); end
         if (c == 1) begin
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL gate_err_cleared: got %b want 0", err); end
         end
         if (c < 5) step();
      end
      n_cmp++; if (clk_en !== 3'b010) begin n_fail++; $display("FAIL gate_clk_en: got %b want 010", clk_en); end
      step();
   endtask

   task automatic test_backpressure();
      pll_ready = 1'b0; pll_lock = 3'b010;
      issue(2'd1, 8'h5A, 1'b1);
      for (int c = 1; c <= 29; c++) begin
         pll_ready = (c >= 12);
         @(negedge clk);
         n_cmp++; if (pll_valid !== ((c >= 5) && (c <= 12))) begin n_fail++; $display("FAIL bp_pll_valid c%0d: got %b", c, pll_valid); end
         if ((c >= 5) && (c <= 12)) begin
            n_cmp++; if (pll_div !== 8'h5A) begin n_fail++; $display("FAIL bp_div c%0d: got %h want 5a", c, pll_div); end
            n_cmp++; if (pll_idx !== 2'd1) begin n_fail++; $display("FAIL bp_idx c%0d: got %0d want 1", c, pll_idx); end
         end
         n_cmp++; if (clk_en[1] !== (c == 29)) begin n_fail++; $display("FAIL bp_clk_en c%0d: got %b want %b", c, clk_en[1], c == 29); end
         n_cmp++; if (done !== (c == 29)) begin n_fail++; $display("FAIL bp_done c%0d: got %b want %b", c, done, c == 29); end
         if (c < 29) step();
      end
      pll_ready = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      cfg_idx = 2'd0; cfg_div = 8'h01; cfg_en = 1'b0; cfg_valid = 1'b1;
      step();
      for (int c = 1; c <= 11; c++) begin
         if (c == 7) cfg_valid = 1'b0;
         @(negedge clk);
         n_cmp++; if (done !== ((c == 5) || (c == 11))) begin n_fail++; $display("FAIL b2b_done c%0d: got %b", c, done); end
         n_cmp++; if (cfg_ready !== (c == 6)) begin n_fail++; $display("FAIL b2b_cfg_ready c%0d: got %b", c, cfg_ready); end
         n_cmp++; if (busy !== (c != 6)) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b", c, busy); end
         if (c < 11) step();
      end
      step();
   endtask

   task automatic test_bad_idx();
      logic [2:0] saved;
      saved = clk_en;
      issue(2'd3, 8'h77, 1'b1);
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err); end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL bad_done: got %b want 1", done); end
      n_cmp++; if (clk_en !== saved) begin n_fail++; $display("FAIL bad_clk_en: got %b want %b", clk_en, saved); end
      n_cmp++; if (pll_valid !== 1'b0) begin n_fail++; $display("FAIL bad_pll_valid: got %b want 0", pll_valid); end
      step();
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL bad_done_after: got %b want 0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy_after: got %b want 0", busy); end
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_sticky: got %b want 1", err); end
      step();
   endtask

   task automatic test_reset_mid();
      pll_lock = 3'b000;
      issue(2'd2, 8'h99, 1'b1);
      for (int c = 1; c <= 7; c++) step();
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (clk_en !== 3'b000) begin n_fail++; $display("FAIL rmid_clk_en: got %b want 000", clk_en); end
      n_cmp++; if (pll_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pll_valid: got %b want 0", pll_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
      n_cmp++; if (pll_div !== 8'h00) begin n_fail++; $display("FAIL rmid_div: got %h want 00", pll_div); end
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cfg_ready: got %b want 1", cfg_ready); end
      n_cmp++; if (pll_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pll_valid_after: got %b want 0", pll_valid); end
   endtask

   initial begin
      test_reset();
      test_happy();
      test_glitch();
      test_timeout();
      test_gate_only();
      test_backpressure();
      test_back_to_back();
      test_bad_idx();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
